reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter W, default `ROB_ENTRY_WIDTH, ROB index width; usable depth D = 2^W - 1.
REQ-002 SHALL have port clk input 1, rising-edge clock.
REQ-003 SHALL have port rst input 1, reset; rst is synchronous, active-high, on clock clk.
REQ-004 SHALL have alloc_valid input 1 (decode requests entry), alloc_rd input 5 (dest reg), alloc_pc input 32 (instruction PC).
REQ-005 SHALL have alloc_ready output 1 (entry available) and alloc_index output W (index granted; drives RAT ROB_index_in).
REQ-006 SHALL have cdb_valid input 1, cdb_index input W, cdb_data input 32 (result), cdb_mispredict input 1, cdb_target input 32 (correct next PC).
REQ-007 SHALL have query_index1/query_index2 inputs W, query_ready1/query_ready2 outputs 1, query_data1/query_data2 outputs 32 (operand lookup for RAT-not-valid operands).
REQ-008 SHALL have commit_we output 1, commit_addr output 5, commit_data output 32, commit_index output W (drive RAT ROB_we/ROB_addr_commit/ROB_data_commit/ROB_index_commit).
REQ-009 SHALL have rollback output 1 and redirect_pc output 32.

Function
REQ-010 SHALL hold D entries, each: busy, done, mispredict, rd[4:0], value[31:0], target[31:0].
REQ-011 SHALL use indices 1..2^W-1 only; index 0 is never allocated (RAT uses 0 as "no producer"); head/tail wrap from 2^W-1 to 1.
REQ-012 SHALL assert alloc_ready = (count < D) && !rollback; alloc_index = tail, combinational.
REQ-013 SHALL, on alloc_valid && alloc_ready at an edge, set entry[tail] busy=1, done=0, mispredict=0, record rd, advance tail, count+1.
REQ-014 SHALL, on cdb_valid for a busy, not-done entry, store value/mispredict/target and set done=1 at that edge; writes to non-busy or done entries are ignored.
REQ-015 SHALL drive commit_we = busy[head] && done[head] && rd[head] != 0 && !rollback, combinational from registered state; commit_addr/data/index = entry[head] rd/value/head.
REQ-016 SHALL retire head (busy=0, head+1, count-1) at any edge where busy[head] && done[head] && !rollback, including rd = 0 entries; max one retire per cycle.
REQ-017 SHALL give CDB-to-commit latency of one cycle: CDB in cycle N -> commit_we earliest in cycle N+1.
REQ-018 SHALL, when retiring head with mispredict=1, clear all busy bits, set head = tail = 1, count = 0 at that edge, and assert rollback for exactly cycle N+1 with redirect_pc = target of that entry.
REQ-019 SHALL, during the rollback cycle, ignore alloc_valid and cdb_valid; rollback low and redirect_pc = 0 otherwise.
REQ-020 SHALL, on simultaneous alloc and retire, leave count unchanged; space freed by retire is not visible to alloc_ready until the next cycle (full stays full).
REQ-021 SHALL drive query_readyN = 1 with query_dataN = cdb_data if cdb_valid && cdb_index == query_indexN (bypass); else query_readyN = busy && done of entry, query_dataN = its value; else 0/0.
REQ-022 SHALL allow simultaneous CDB write and retire of different entries without interaction.

Reset
REQ-023 SHALL, on rst, clear all busy/done/mispredict bits, head = tail = 1, count = 0, rollback = 0; rst overrides all events in that cycle.
REQ-024 SHALL present after reset: alloc_ready=1, alloc_index=1, commit_we=0, commit_addr=0, commit_data=0, commit_index=0, rollback=0, redirect_pc=0, query_ready*=0, query_data*=0.

Structure
REQ-025 SHALL take ROB_ENTRY_WIDTH from the shared defines header; entry field widths stay local.
REQ-026 SHALL be one module, no sub-modules; index-increment-with-wrap is a local function.

Verification
REQ-027 SHALL cover: reset, alloc rd=5 -> alloc_index=1; CDB idx1 data 0xDEADBEEF -> next cycle commit_we=1, addr=5, data=0xDEADBEEF, index=1.
REQ-028 SHALL cover: allocate D entries -> alloc_ready=0; retire+alloc same cycle -> count stays D; index wraps from 2^W-1 to 1, never 0.
REQ-029 SHALL cover: out-of-order CDB (idx3, then idx2, then idx1) -> commits in order 1,2,3 on consecutive cycles.
REQ-030 SHALL cover: head mispredict target 0x100 with 3 younger entries -> rollback=1 one cycle, redirect_pc=0x100, then alloc_index=1, count=0; CDB in rollback cycle ignored.
REQ-031 SHALL cover: query_index1=2 with cdb_valid idx2 data 7 same cycle -> query_ready1=1, query_data1=7; rd=0 entry retires with commit_we=0.
REQ-032 SHALL cover: rst asserted with 4 busy entries -> all REQ-024 values next cycle.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry payload layout and field widths.
// ROB_ENTRY_WIDTH normally comes from the project defines; the fallback keeps this slice standalone.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

package reorder_buffer_pkg;

  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  // Per-entry payload; the control bits (busy/done/mispredict) live in flat vectors in the top.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] target;
  } rob_payload_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, collects CDB results out of order,
// commits from head to the RAT and flushes everything on a mispredicted head.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int W = `ROB_ENTRY_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: an allocation happens at an edge where alloc_valid && alloc_ready.
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  input  logic [31:0]       alloc_pc,
  output logic              alloc_ready,
  output logic [W-1:0]      alloc_index,
  input  logic              cdb_valid,
  input  logic [W-1:0]      cdb_index,
  input  logic [31:0]       cdb_data,
  input  logic              cdb_mispredict,
  input  logic [31:0]       cdb_target,
  input  logic [W-1:0]      query_index1,
  input  logic [W-1:0]      query_index2,
  output logic              query_ready1,
  output logic              query_ready2,
  output logic [31:0]       query_data1,
  output logic [31:0]       query_data2,
  output logic              commit_we,
  output logic [4:0]        commit_addr,
  output logic [31:0]       commit_data,
  output logic [W-1:0]      commit_index,
  output logic              rollback,
  output logic [31:0]       redirect_pc
);

  localparam int N = 1 << W;
  localparam logic [W-1:0] MAX_IDX = {W{1'b1}};
  localparam logic [W-1:0] FIRST_IDX = W'(1);

  logic [N-1:0]   busy_q;
  logic [N-1:0]   done_q;
  logic [N-1:0]   misp_q;
  rob_payload_t   pay_q [N];
  logic [W-1:0]   head_q;
  logic [W-1:0]   tail_q;
  logic [W-1:0]   count_q;
  logic           rollback_q;
  logic [31:0]    redirect_q;

  logic           alloc_fire;
  logic           cdb_fire;
  logic           retire;
  logic           flush;

  // The PC is carried by the decode interface but no entry field needs it.
  logic           unused_pc;
  assign unused_pc = ^alloc_pc;

  // Index 0 means "no producer" to the RAT, so the ring runs 1..MAX_IDX.
  function automatic logic [W-1:0] next_idx(input logic [W-1:0] idx);
    return (idx == MAX_IDX) ? FIRST_IDX : idx + FIRST_IDX;
  endfunction

  always_comb begin
    retire      = busy_q[head_q] && done_q[head_q] && !rollback_q;
    flush       = retire && misp_q[head_q];
    alloc_ready = (count_q != MAX_IDX) && !rollback_q;
    alloc_index = tail_q;
    alloc_fire  = alloc_valid && alloc_ready;
    cdb_fire    = cdb_valid && !rollback_q && busy_q[cdb_index] && !done_q[cdb_index];
  end

  always_comb begin
    commit_we    = retire && (pay_q[head_q].rd != '0);
    commit_addr  = '0;
    commit_data  = '0;
    commit_index = '0;
    if (commit_we) begin
      commit_addr  = pay_q[head_q].rd;
      commit_data  = pay_q[head_q].value;
      commit_index = head_q;
    end
  end

  // Operand lookup: a result on the CDB this cycle wins over the stored copy.
  always_comb begin
    query_ready1 = 1'b0;
    query_data1  = '0;
    if (cdb_valid && (cdb_index == query_index1)) begin
      query_ready1 = 1'b1;
      query_data1  = cdb_data;
    end else if (busy_q[query_index1] && done_q[query_index1]) begin
      query_ready1 = 1'b1;
      query_data1  = pay_q[query_index1].value;
    end
  end

  always_comb begin
    query_ready2 = 1'b0;
    query_data2  = '0;
    if (cdb_valid && (cdb_index == query_index2)) begin
      query_ready2 = 1'b1;
      query_data2  = cdb_data;
    end else if (busy_q[query_index2] && done_q[query_index2]) begin
      query_ready2 = 1'b1;
      query_data2  = pay_q[query_index2].value;
    end
  end

  assign rollback    = rollback_q;
  assign redirect_pc = redirect_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      done_q     <= '0;
      misp_q     <= '0;
      head_q     <= FIRST_IDX;
      tail_q     <= FIRST_IDX;
      count_q    <= '0;
      rollback_q <= 1'b0;
      redirect_q <= '0;
    end else begin
      rollback_q <= flush;
      redirect_q <= flush ? pay_q[head_q].target : '0;
      if (flush) begin
        busy_q  <= '0;
        done_q  <= '0;
        misp_q  <= '0;
        head_q  <= FIRST_IDX;
        tail_q  <= FIRST_IDX;
        count_q <= '0;
      end else begin
        // Tail is never busy when alloc fires and the CDB only hits busy entries,
        // so these per-entry writes never touch the same bit.
        if (alloc_fire) begin
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= 1'b0;
          misp_q[tail_q] <= 1'b0;
          tail_q         <= next_idx(tail_q);
        end
        if (cdb_fire) begin
          done_q[cdb_index] <= 1'b1;
          misp_q[cdb_index] <= cdb_mispredict;
        end
        if (retire) begin
          busy_q[head_q] <= 1'b0;
          done_q[head_q] <= 1'b0;
          head_q         <= next_idx(head_q);
        end
        case ({alloc_fire, retire})
          2'b10:   count_q <= count_q + FIRST_IDX;
          2'b01:   count_q <= count_q - FIRST_IDX;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload needs no reset: it is only observed through busy/done.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pay_q[tail_q].rd <= alloc_rd;
    end
    if (cdb_fire) begin
      pay_q[cdb_index].value  <= cdb_data;
      pay_q[cdb_index].target <= cdb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based in-order retirement model.
module tb_reorder_buffer;

  localparam int W = 3;
  localparam int D = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic [W-1:0] alloc_index;
  logic        cdb_valid;
  logic [W-1:0] cdb_index;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [W-1:0] query_index1, query_index2;
  logic        query_ready1, query_ready2;
  logic [31:0] query_data1, query_data2;
  logic        commit_we;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;
  logic [W-1:0] commit_index;
  logic        rollback;
  logic [31:0] redirect_pc;

  reorder_buffer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .query_index1(query_index1), .query_index2(query_index2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_data1(query_data1), .query_data2(query_data2),
    .commit_we(commit_we), .commit_addr(commit_addr), .commit_data(commit_data),
    .commit_index(commit_index), .rollback(rollback), .redirect_pc(redirect_pc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0;
    cdb_valid = 1'b0; cdb_index = '0; cdb_data = '0;
    cdb_mispredict = 1'b0; cdb_target = '0;
    query_index1 = '0; query_index2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] rd);
    alloc_valid = 1'b1; alloc_rd = rd; alloc_pc = $urandom;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_cdb(input logic [W-1:0] idx, input logic [31:0] data,
                        input logic misp, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_index = idx; cdb_data = data;
    cdb_mispredict = misp; cdb_target = tgt;
    tick();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic        cv;
    logic [2:0]  ci;
    logic [31:0] cd;
    logic [2:0]  q1;
    logic        e_ar;
    logic [2:0]  e_ai;
    logic        e_we;
    logic [4:0]  e_ca;
    logic [31:0] e_cd;
    logic [2:0]  e_cx;
    logic        e_qr;
    logic [31:0] e_qd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                              input logic cv, input logic [2:0] ci, input logic [31:0] cd,
                              input logic [2:0] q1, input logic e_ar, input logic [2:0] e_ai,
                              input logic e_we, input logic [4:0] e_ca, input logic [31:0] e_cd,
                              input logic [2:0] e_cx, input logic e_qr, input logic [31:0] e_qd);
    vec_t v;
    v.rst = r; v.av = av; v.ard = ard; v.cv = cv; v.ci = ci; v.cd = cd; v.q1 = q1;
    v.e_ar = e_ar; v.e_ai = e_ai; v.e_we = e_we; v.e_ca = e_ca; v.e_cd = e_cd;
    v.e_cx = e_cx; v.e_qr = e_qr; v.e_qd = e_qd;
    return v;
  endfunction

  vec_t vt[20];

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];          // in-flight entry indices, oldest first
  logic [4:0]   m_rd   [8];
  bit           m_done [8];
  bit           m_misp [8];
  logic [31:0]  m_val  [8];
  logic [31:0]  m_tgt  [8];
  int           m_tail;
  bit           m_rb;
  logic [31:0]  m_rpc;

  function automatic bit in_flight(input logic [W-1:0] idx);
    foreach (exp_q[k]) if (exp_q[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_query(input logic [W-1:0] qi, output logic r, output logic [31:0] d);
    r = 1'b0; d = '0;
    if (cdb_valid && cdb_index == qi) begin
      r = 1'b1; d = cdb_data;
    end else if (in_flight(qi) && m_done[qi]) begin
      r = 1'b1; d = m_val[qi];
    end
  endtask

  logic         e_ar, e_we, e_qr1, e_qr2, m_retire, m_flush, cdb_ok;
  logic [4:0]   e_ca;
  logic [31:0]  e_cd, e_qd1, e_qd2;
  logic [W-1:0] e_cx, h;
  int           pend[$];

  initial begin
    idle_inputs();
    rst = 1'b1;

    // rows: rst av rd | cv ci data | q1 || ready idx | we addr data index | qr qd
    vt[0]  = mk(0,0,0, 0,0,0,            0, 1,1, 0,0,0,0,            0,0);
    vt[1]  = mk(0,1,5, 0,0,0,            0, 1,1, 0,0,0,0,            0,0);
    vt[2]  = mk(0,0,0, 1,1,32'hDEADBEEF, 1, 1,2, 0,0,0,0,            1,32'hDEADBEEF);
    vt[3]  = mk(0,0,0, 0,0,0,            1, 1,2, 1,5,32'hDEADBEEF,1, 1,32'hDEADBEEF);
    vt[4]  = mk(1,0,0, 0,0,0,            1, 1,2, 0,0,0,0,            0,0);
    vt[5]  = mk(0,1,1, 0,0,0,            0, 1,1, 0,0,0,0,            0,0);
    vt[6]  = mk(0,1,2, 0,0,0,            0, 1,2, 0,0,0,0,            0,0);
    vt[7]  = mk(0,1,3, 0,0,0,            0, 1,3, 0,0,0,0,            0,0);
    vt[8]  = mk(0,0,0, 1,3,32'h33,       3, 1,4, 0,0,0,0,            1,32'h33);
    vt[9]  = mk(0,0,0, 1,2,32'h7,        2, 1,4, 0,0,0,0,            1,32'h7);
    vt[10] = mk(0,0,0, 1,1,32'h11,       2, 1,4, 0,0,0,0,            1,32'h7);
    vt[11] = mk(0,0,0, 0,0,0,            0, 1,4, 1,1,32'h11,1,       0,0);
    vt[12] = mk(0,0,0, 0,0,0,            0, 1,4, 1,2,32'h7,2,        0,0);
    vt[13] = mk(0,0,0, 0,0,0,            0, 1,4, 1,3,32'h33,3,       0,0);
    vt[14] = mk(0,1,0, 0,0,0,            0, 1,4, 0,0,0,0,            0,0);
    vt[15] = mk(0,0,0, 1,4,32'h55,       0, 1,5, 0,0,0,0,            0,0);
    vt[16] = mk(0,0,0, 0,0,0,            4, 1,5, 0,0,0,0,            1,32'h55);
    vt[17] = mk(0,1,7, 0,0,0,            4, 1,5, 0,0,0,0,            0,0);
    vt[18] = mk(0,0,0, 1,5,32'h77,       0, 1,6, 0,0,0,0,            0,0);
    vt[19] = mk(0,0,0, 0,0,0,            0, 1,6, 1,7,32'h77,5,       0,0);

    reset_dut();
    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst;
      alloc_valid = vt[i].av; alloc_rd = vt[i].ard; alloc_pc = $urandom;
      cdb_valid = vt[i].cv; cdb_index = vt[i].ci; cdb_data = vt[i].cd;
      cdb_mispredict = 1'b0; cdb_target = $urandom;
      query_index1 = vt[i].q1; query_index2 = '0;
      #1;
      chk($sformatf("tbl%0d alloc_ready", i), alloc_ready, vt[i].e_ar);
      chk($sformatf("tbl%0d alloc_index", i), alloc_index, vt[i].e_ai);
      chk($sformatf("tbl%0d commit_we", i), commit_we, vt[i].e_we);
      chk($sformatf("tbl%0d commit_addr", i), commit_addr, vt[i].e_ca);
      chk($sformatf("tbl%0d commit_data", i), commit_data, vt[i].e_cd);
      chk($sformatf("tbl%0d commit_index", i), commit_index, vt[i].e_cx);
      chk($sformatf("tbl%0d rollback", i), rollback, 0);
      chk($sformatf("tbl%0d redirect_pc", i), redirect_pc, 0);
      chk($sformatf("tbl%0d query_ready1", i), query_ready1, vt[i].e_qr);
      chk($sformatf("tbl%0d query_data1", i), query_data1, vt[i].e_qd);
      chk($sformatf("tbl%0d query_ready2", i), query_ready2, 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();

    // Fill to D entries, check full and tail wrap, then alloc blocked while retiring.
    reset_dut();
    for (int i = 0; i < D; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
      #1;
      chk($sformatf("fill%0d ready", i), alloc_ready, 1);
      chk($sformatf("fill%0d index", i), alloc_index, i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    chk("full ready", alloc_ready, 0);
    chk("full tail_wrap", alloc_index, 1);
    do_cdb(3'd1, 32'hA1, 1'b0, 32'h0);
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    #1;
    chk("full retire commit_index", commit_index, 1);
    chk("full retire commit_data", commit_data, 32'hA1);
    chk("full stays full", alloc_ready, 0);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("after retire ready", alloc_ready, 1);
    chk("after retire index", alloc_index, 1);
    do_cdb(3'd2, 32'hA2, 1'b0, 32'h0);
    alloc_valid = 1'b1; alloc_rd = 5'd10;
    #1;
    chk("alloc+retire commit_index", commit_index, 2);
    chk("alloc+retire ready", alloc_ready, 1);
    tick();
    #1;
    chk("alloc+retire next index", alloc_index, 2);
    chk("alloc+retire one slot", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("count held then full", alloc_ready, 0);
    chk("wrap tail index", alloc_index, 3);

    // Mispredicted head with three younger entries.
    reset_dut();
    for (int i = 1; i <= 4; i++) do_alloc(5'(i));
    do_cdb(3'd1, 32'hAA, 1'b1, 32'h100);
    #1;
    chk("misp commit_we", commit_we, 1);
    chk("misp commit_addr", commit_addr, 1);
    chk("misp pre rollback", rollback, 0);
    chk("misp pre redirect", redirect_pc, 0);
    tick();
    cdb_valid = 1'b1; cdb_index = 3'd2; cdb_data = 32'h22;
    alloc_valid = 1'b1; alloc_rd = 5'd6;
    #1;
    chk("rb rollback", rollback, 1);
    chk("rb redirect_pc", redirect_pc, 32'h100);
    chk("rb alloc_ready", alloc_ready, 0);
    chk("rb alloc_index", alloc_index, 1);
    chk("rb commit_we", commit_we, 0);
    tick();
    idle_inputs();
    query_index1 = 3'd2;
    #1;
    chk("post rb rollback", rollback, 0);
    chk("post rb redirect_pc", redirect_pc, 0);
    chk("post rb alloc_ready", alloc_ready, 1);
    chk("post rb alloc_index", alloc_index, 1);
    chk("post rb cdb ignored", query_ready1, 0);
    chk("post rb commit_we", commit_we, 0);
    do_alloc(5'd6);
    do_cdb(3'd1, 32'h5, 1'b0, 32'h0);
    #1;
    chk("post rb commit_index", commit_index, 1);
    chk("post rb commit_addr", commit_addr, 6);
    chk("post rb commit_data", commit_data, 5);

    // Reset with four busy entries, one of them done.
    reset_dut();
    for (int i = 1; i <= 4; i++) do_alloc(5'(i + 10));
    do_cdb(3'd1, 32'h1, 1'b0, 32'h0);
    rst = 1'b1; alloc_valid = 1'b1; cdb_valid = 1'b1; cdb_index = 3'd2;
    tick();
    rst = 1'b0;
    idle_inputs();
    query_index1 = 3'd1; query_index2 = 3'd2;
    #1;
    chk("rst alloc_ready", alloc_ready, 1);
    chk("rst alloc_index", alloc_index, 1);
    chk("rst commit_we", commit_we, 0);
    chk("rst commit_addr", commit_addr, 0);
    chk("rst commit_data", commit_data, 0);
    chk("rst commit_index", commit_index, 0);
    chk("rst rollback", rollback, 0);
    chk("rst redirect_pc", redirect_pc, 0);
    chk("rst query_ready1", query_ready1, 0);
    chk("rst query_data1", query_data1, 0);
    chk("rst query_ready2", query_ready2, 0);
    chk("rst query_data2", query_data2, 0);

    // Randomized traffic against the in-order retirement model.
    reset_dut();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      m_done[k] = 1'b0; m_misp[k] = 1'b0; m_val[k] = '0; m_tgt[k] = '0; m_rd[k] = '0;
    end
    m_tail = 1; m_rb = 1'b0; m_rpc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      alloc_valid = ($urandom_range(0, 99) < 60);
      alloc_rd = 5'($urandom_range(0, 31));
      alloc_pc = $urandom;
      cdb_valid = ($urandom_range(0, 99) < 50);
      pend.delete();
      foreach (exp_q[k]) if (!m_done[exp_q[k]]) pend.push_back(int'(exp_q[k]));
      if (pend.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_index = 3'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        cdb_index = 3'($urandom_range(0, 7));
      cdb_data = $urandom;
      cdb_mispredict = ($urandom_range(0, 19) == 0);
      cdb_target = $urandom;
      query_index1 = 3'($urandom_range(0, 7));
      query_index2 = 3'($urandom_range(0, 7));
      #1;

      e_ar = (exp_q.size() < D) && !m_rb;
      m_retire = !m_rb && (exp_q.size() > 0) && m_done[exp_q[0]];
      h = (exp_q.size() > 0) ? exp_q[0] : '0;
      m_flush = m_retire && m_misp[h];
      e_we = m_retire && (m_rd[h] != 0);
      e_ca = e_we ? m_rd[h] : '0;
      e_cd = e_we ? m_val[h] : '0;
      e_cx = e_we ? h : '0;
      model_query(query_index1, e_qr1, e_qd1);
      model_query(query_index2, e_qr2, e_qd2);

      chk("rnd alloc_ready", alloc_ready, e_ar);
      chk("rnd alloc_index", alloc_index, m_tail);
      chk("rnd commit_we", commit_we, e_we);
      chk("rnd commit_addr", commit_addr, e_ca);
      chk("rnd commit_data", commit_data, e_cd);
      chk("rnd commit_index", commit_index, e_cx);
      chk("rnd rollback", rollback, m_rb);
      chk("rnd redirect_pc", redirect_pc, m_rpc);
      chk("rnd query_ready1", query_ready1, e_qr1);
      chk("rnd query_data1", query_data1, e_qd1);
      chk("rnd query_ready2", query_ready2, e_qr2);
      chk("rnd query_data2", query_data2, e_qd2);

      cdb_ok = cdb_valid && !m_rb && in_flight(cdb_index) && !m_done[cdb_index];
      if (m_flush) begin
        m_rpc = m_tgt[h];
        exp_q.delete();
        for (int k = 0; k < 8; k++) m_done[k] = 1'b0;
        m_tail = 1;
      end else begin
        m_rpc = '0;
        if (cdb_ok) begin
          m_done[cdb_index] = 1'b1;
          m_val[cdb_index]  = cdb_data;
          m_misp[cdb_index] = cdb_mispredict;
          m_tgt[cdb_index]  = cdb_target;
        end
        if (m_retire) begin
          m_done[h] = 1'b0;
          void'(exp_q.pop_front());
        end
        if (alloc_valid && e_ar) begin
          exp_q.push_back(3'(m_tail));
          m_rd[m_tail] = alloc_rd;
          m_done[m_tail] = 1'b0;
          m_tail = (m_tail % D) + 1;
        end
      end
      m_rb = m_flush;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
